// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage request/response bundle between the pipeline
// (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata_last;
    logic [31:0] mem_rdata;
    logic        stallreq_from_mem;

    modport master (
        output mem_en,
        output mem_we,
        output sel,
        output mem_addr,
        output mem_wdata_last,
        input  mem_rdata,
        input  stallreq_from_mem
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  sel,
        input  mem_addr,
        input  mem_wdata_last,
        output mem_rdata,
        output stallreq_from_mem
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM for the pipelined MIPS core.
// Each access stalls the pipeline for LATENCY cycles, followed by one DONE cycle
// in which read data is valid. Define DMEM_ADDR_CHECK_EN to add the addr_err
// output and suppress accesses above the RAM range (default: high bits alias).
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,  // word-address bits, at most 29
    parameter int unsigned LATENCY    = 2    // 1..15
) (
    input  logic clk,
    input  logic rst,
    dmem_responder_if.slave bus
`ifdef DMEM_ADDR_CHECK_EN
    ,
    output logic addr_err
`endif
);

    localparam int unsigned Depth  = 1 << ADDR_WIDTH;
    localparam logic [3:0]  LatM1  = 4'(LATENCY - 1);
    localparam bit          Single = (LATENCY == 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic [3:0]              r_sel;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic [31:0]             r_mem [Depth];
`ifdef DMEM_ADDR_CHECK_EN
    logic                    r_oor;
    logic                    r_addr_err;
`endif

    logic                    w_accept;
    logic                    w_to_done;
    logic                    w_we;
    logic [3:0]              w_sel;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [31:0]             w_wdata;
    logic                    w_oor;
    logic                    w_unused;

    // Byte offset and (without range checking) upper bits never affect the word index.
    assign w_unused = ^{bus.mem_addr[1:0], bus.mem_addr[31:ADDR_WIDTH+2]};

    // Effective access fields: live inputs in the accept cycle (needed when
    // LATENCY=1 completes on the accepting edge), latched copies afterwards.
    always_comb begin
        w_accept  = (r_state == StIdle) && bus.mem_en;
        w_to_done = (w_accept && Single) || ((r_state == StBusy) && (r_cnt <= 4'd1));
        w_we      = w_accept ? bus.mem_we : r_we;
        w_sel     = w_accept ? bus.sel : r_sel;
        w_idx     = w_accept ? bus.mem_addr[ADDR_WIDTH+1:2] : r_idx;
        w_wdata   = w_accept ? bus.mem_wdata_last : r_wdata;
`ifdef DMEM_ADDR_CHECK_EN
        w_oor     = w_accept ? ((bus.mem_addr >> (ADDR_WIDTH + 2)) != '0) : r_oor;
`else
        w_oor     = 1'b0;
`endif
    end

    // Stall covers the request cycle plus every BUSY cycle: LATENCY cycles in total.
    always_comb begin
        bus.stallreq_from_mem = w_accept || (r_state == StBusy);
    end

    assign bus.mem_rdata = r_rdata;
`ifdef DMEM_ADDR_CHECK_EN
    assign addr_err = r_addr_err;
`endif

    // Access FSM: accept, count down the stall, complete, plus registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_sel      <= 4'd0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
`ifdef DMEM_ADDR_CHECK_EN
            r_oor      <= 1'b0;
            r_addr_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.mem_en) begin
                        r_we    <= bus.mem_we;
                        r_sel   <= bus.sel;
                        r_idx   <= bus.mem_addr[ADDR_WIDTH+1:2];
                        r_wdata <= bus.mem_wdata_last;
`ifdef DMEM_ADDR_CHECK_EN
                        r_oor   <= w_oor;
`endif
                        r_cnt   <= LatM1;
                        r_state <= Single ? StDone : StBusy;
                    end
                end
                StBusy: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= StDone;
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase

            if (w_to_done && !w_we) begin
                r_rdata <= w_oor ? 32'd0 : r_mem[w_idx];
            end
`ifdef DMEM_ADDR_CHECK_EN
            r_addr_err <= w_to_done && w_oor;
`endif
        end
    end

    // RAM write with per-lane enables; contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (!rst && w_to_done && w_we && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (w_sel[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
